// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for a 4-stage pipeline with IF/ID, ID/EX
//   and EX/WB registers. It detects load-use hazards, taken branches and
//   multi-cycle EX operations. It drives the enable and bubble controls of
//   each pipeline register. A bubble makes the register load NOP_OP, and
//   writeback is suppressed for NOP_OP further down the pipe. The block also
//   keeps a saturating count of stalled cycles for performance debug.
//
// Ports
//   i_clk            clock; all state changes on posedge
//   i_rstd           synchronous active-low reset
//   i_id_op          opcode held in IF/ID (instruction being decoded)
//   i_id_rs          source register 1 of the decoded instruction
//   i_id_rt          source register 2 of the decoded instruction
//   i_ex_op          opcode held in ID/EX (instruction in EX)
//   i_ex_wreg        destination register of the instruction in EX
//   i_br_taken       branch in EX resolved taken this cycle
//   o_pc_en          PC update enable
//   o_fd_en          IF/ID load enable
//   o_fd_flush       IF/ID loads NOP_OP
//   o_de_en          ID/EX load enable
//   o_de_bubble      ID/EX loads NOP_OP
//   o_ew_bubble      EX/WB loads NOP_OP
//   o_state          0=RUN 1=MC_BUSY 2=FLUSH
//   o_stall_cycles   cycles with o_pc_en=0 while out of reset, saturating
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter logic [5:0] NOP_OP    = 6'd55,
  parameter logic [5:0] LOAD_OP   = 6'd16,
  parameter logic [5:0] MUL_OP    = 6'd24,
  parameter int         MUL_LAT   = 4,
  parameter bit         IMEM_SYNC = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rstd,
  input  logic [5:0]  i_id_op,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [5:0]  i_ex_op,
  input  logic [4:0]  i_ex_wreg,
  input  logic        i_br_taken,
  output logic        o_pc_en,
  output logic        o_fd_en,
  output logic        o_fd_flush,
  output logic        o_de_en,
  output logic        o_de_bubble,
  output logic        o_ew_bubble,
  output logic [1:0]  o_state,
  output logic [15:0] o_stall_cycles
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MC    = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // The mc_enter cycle is the first EX cycle and the counter==0 cycle is
  // the last, so MUL_LAT-2 intermediate cycles remain.
  localparam logic [3:0] MC_INIT = 4'(MUL_LAT - 2);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_mc_cnt;
  logic [3:0]  w_mc_cnt_nxt;
  logic [15:0] r_stall_cycles;

  logic w_load_use;
  logic w_mc_enter;
  logic w_pc_en;
  logic w_fd_en;
  logic w_fd_flush;
  logic w_de_en;
  logic w_de_bubble;
  logic w_ew_bubble;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A load to r0 never creates a dependency. A NOP in decode reads nothing.
  assign w_load_use = (i_ex_op == LOAD_OP) && (i_ex_wreg != 5'd0) &&
                      (i_id_op != NOP_OP) &&
                      ((i_ex_wreg == i_id_rs) || (i_ex_wreg == i_id_rt));
  assign w_mc_enter = (r_state == S_RUN) && (i_ex_op == MUL_OP);

  // State register, multi-cycle counter and stall counter
  always_ff @(posedge i_clk) begin
    if (!i_rstd) begin
      r_state        <= S_RUN;
      r_mc_cnt       <= 4'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (!w_pc_en)
        r_stall_cycles <= sat_inc16(r_stall_cycles);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    case (r_state)
      S_RUN: begin
        if (i_br_taken) begin
          w_state_nxt = IMEM_SYNC ? S_FLUSH : S_RUN;
        end else if (w_mc_enter) begin
          w_state_nxt  = S_MC;
          w_mc_cnt_nxt = MC_INIT;
        end
      end
      S_MC: begin
        if (r_mc_cnt == 4'd0)
          w_state_nxt = S_RUN;
        else
          w_mc_cnt_nxt = r_mc_cnt - 4'd1;
      end
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    w_pc_en     = 1'b1;
    w_fd_en     = 1'b1;
    w_de_en     = 1'b1;
    w_fd_flush  = 1'b0;
    w_de_bubble = 1'b0;
    w_ew_bubble = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_br_taken) begin
          // PC loads the branch target; the two younger instructions die.
          w_fd_flush  = 1'b1;
          w_de_bubble = 1'b1;
        end else if (w_mc_enter) begin
          w_pc_en     = 1'b0;
          w_fd_en     = 1'b0;
          w_de_en     = 1'b0;
          w_ew_bubble = 1'b1;
        end else if (w_load_use) begin
          // One bubble is enough: next cycle the load sits in EX/WB and
          // the forwarding path supplies its value.
          w_pc_en     = 1'b0;
          w_fd_en     = 1'b0;
          w_de_bubble = 1'b1;
        end
      end
      S_MC: begin
        if (r_mc_cnt == 4'd0) begin
          // Final EX cycle: EX/WB takes the single MUL result and ID/EX
          // takes a bubble so the MUL is not executed twice.
          w_de_bubble = 1'b1;
        end else begin
          w_pc_en     = 1'b0;
          w_fd_en     = 1'b0;
          w_de_en     = 1'b0;
          w_ew_bubble = 1'b1;
        end
      end
      S_FLUSH: begin
        // Kills the fetch issued before the target address reached the
        // synchronous instruction memory.
        w_fd_flush = 1'b1;
      end
      default: ;
    endcase
    if (!i_rstd) begin
      w_pc_en     = 1'b0;
      w_fd_en     = 1'b0;
      w_de_en     = 1'b0;
      w_fd_flush  = 1'b1;
      w_de_bubble = 1'b1;
      w_ew_bubble = 1'b1;
    end
  end

  assign o_pc_en        = w_pc_en;
  assign o_fd_en        = w_fd_en;
  assign o_fd_flush     = w_fd_flush;
  assign o_de_en        = w_de_en;
  assign o_de_bubble    = w_de_bubble;
  assign o_ew_bubble    = w_ew_bubble;
  assign o_state        = r_state;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rstd;
  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [5:0]  ex_op;
  logic [4:0]  ex_wreg;
  logic        br_taken;
  logic        pc_en;
  logic        fd_en;
  logic        fd_flush;
  logic        de_en;
  logic        de_bubble;
  logic        ew_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl dut (
    .i_clk          (clk),
    .i_rstd         (rstd),
    .i_id_op        (id_op),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_op        (ex_op),
    .i_ex_wreg      (ex_wreg),
    .i_br_taken     (br_taken),
    .o_pc_en        (pc_en),
    .o_fd_en        (fd_en),
    .o_fd_flush     (fd_flush),
    .o_de_en        (de_en),
    .o_de_bubble    (de_bubble),
    .o_ew_bubble    (ew_bubble),
    .o_state        (state),
    .o_stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_op = 6'd0; id_rs = 5'd1; id_rt = 5'd2;
    ex_op = 6'd0; ex_wreg = 5'd0; br_taken = 1'b0;
  endtask

  initial begin
    rstd = 1'b0;
    idle();

    // Reset held for two cycles
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_fd_en", fd_en, 0);
    chk("rst_de_en", de_en, 0);
    chk("rst_fd_flush", fd_flush, 1);
    chk("rst_de_bubble", de_bubble, 1);
    chk("rst_ew_bubble", ew_bubble, 1);
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_pc_en_hold", pc_en, 0);
    rstd = 1'b1;
    #1;
    chk("rel_pc_en", pc_en, 1);
    chk("rel_fd_flush", fd_flush, 0);
    chk("rel_de_bubble", de_bubble, 0);
    tick();
    chk("rel_stall", stall_cycles, 0);
    chk("rel_state", state, 0);

    // Load-use on rt
    ex_op = 6'd16; ex_wreg = 5'd5; id_rt = 5'd5;
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_fd_en", fd_en, 0);
    chk("lu_de_bubble", de_bubble, 1);
    chk("lu_de_en", de_en, 1);
    tick();
    ex_op = 6'd55; ex_wreg = 5'd0; id_rt = 5'd2;
    #1;
    chk("lu_after_pc_en", pc_en, 1);
    chk("lu_stall", stall_cycles, 1);
    // Load-use on rs
    ex_op = 6'd16; ex_wreg = 5'd7; id_rs = 5'd7;
    #1;
    chk("lu_rs_pc_en", pc_en, 0);
    tick();
    chk("lu_rs_stall", stall_cycles, 2);
    // Load to r0: no dependency
    ex_wreg = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    chk("lu_r0_pc_en", pc_en, 1);
    chk("lu_r0_de_bubble", de_bubble, 0);
    tick();
    // NOP in decode: no dependency
    ex_wreg = 5'd5; id_rt = 5'd5; id_op = 6'd55;
    #1;
    chk("lu_nop_pc_en", pc_en, 1);
    tick();
    chk("lu_none_stall", stall_cycles, 2);
    idle();

    // MUL with MUL_LAT=4
    ex_op = 6'd24;
    #1;
    chk("mul0_state", state, 0);
    chk("mul0_pc_en", pc_en, 0);
    chk("mul0_de_en", de_en, 0);
    chk("mul0_ew_bubble", ew_bubble, 1);
    tick();
    br_taken = 1'b1;
    #1;
    chk("mul1_state", state, 1);
    chk("mul1_pc_en", pc_en, 0);
    chk("mul1_br_ignored", fd_flush, 0);
    chk("mul1_ew_bubble", ew_bubble, 1);
    tick();
    br_taken = 1'b0;
    #1;
    chk("mul2_state", state, 1);
    chk("mul2_pc_en", pc_en, 0);
    tick();
    chk("mul3_state", state, 1);
    chk("mul3_pc_en", pc_en, 1);
    chk("mul3_ew_bubble", ew_bubble, 0);
    chk("mul3_de_bubble", de_bubble, 1);
    chk("mul3_de_en", de_en, 1);
    tick();
    ex_op = 6'd55;
    #1;
    chk("mul4_state", state, 0);
    chk("mul_stall", stall_cycles, 5);
    chk("mul4_pc_en", pc_en, 1);

    // Taken branch with synchronous instruction memory
    idle();
    br_taken = 1'b1;
    #1;
    chk("br_fd_flush", fd_flush, 1);
    chk("br_de_bubble", de_bubble, 1);
    chk("br_pc_en", pc_en, 1);
    chk("br_state", state, 0);
    tick();
    chk("fl_state", state, 2);
    chk("fl_fd_flush", fd_flush, 1);
    chk("fl_de_bubble", de_bubble, 0);
    chk("fl_pc_en", pc_en, 1);
    tick();
    br_taken = 1'b0;
    #1;
    chk("fl_exit_state", state, 0);
    chk("fl_exit_fd_flush", fd_flush, 0);
    chk("br_stall", stall_cycles, 5);

    // Branch beats load-use
    ex_op = 6'd16; ex_wreg = 5'd5; id_rt = 5'd5; br_taken = 1'b1;
    #1;
    chk("brlu_pc_en", pc_en, 1);
    chk("brlu_fd_flush", fd_flush, 1);
    tick();
    br_taken = 1'b0;
    #1;
    chk("brlu_state", state, 2);
    chk("brlu_fl_pc_en", pc_en, 1);
    tick();
    chk("brlu_stall", stall_cycles, 5);
    chk("brlu_back_state", state, 0);

    // Branch beats MUL entry
    idle();
    ex_op = 6'd24; br_taken = 1'b1;
    #1;
    chk("brmul_pc_en", pc_en, 1);
    tick();
    idle();
    #1;
    chk("brmul_state", state, 2);
    tick();

    // Reset during MC_BUSY
    ex_op = 6'd24;
    tick();
    chk("mcrst_state_pre", state, 1);
    chk("mcrst_stall_pre", stall_cycles, 6);
    rstd = 1'b0;
    #1;
    chk("mcrst_pc_en", pc_en, 0);
    tick();
    rstd = 1'b1; ex_op = 6'd55;
    #1;
    chk("mcrst_state", state, 0);
    chk("mcrst_stall", stall_cycles, 0);
    chk("mcrst_pc_en_after", pc_en, 1);
    tick();
    chk("mcrst_state_hold", state, 0);

    // Reset during FLUSH
    idle();
    br_taken = 1'b1;
    tick();
    chk("flrst_state_pre", state, 2);
    br_taken = 1'b0; rstd = 1'b0;
    tick();
    rstd = 1'b1;
    #1;
    chk("flrst_state", state, 0);
    chk("flrst_fd_flush", fd_flush, 0);

    // Saturation: 70000 consecutive load-use stall cycles
    ex_op = 6'd16; ex_wreg = 5'd5; id_rt = 5'd5;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", stall_cycles, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cycles, 16'hFFFF);
    for (int i = 0; i < 4465; i++) tick();
    chk("sat_hold", stall_cycles, 16'hFFFF);
    idle();
    tick();
    chk("sat_end_state", state, 0);
    chk("sat_end_stall", stall_cycles, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
